// File: rtl/emu_ram_tester.sv
// AXI4 write-then-read-back traffic generator for the emulated RAM model.
// Writes NUM_BURSTS INCR bursts of a seeded pattern, reads them back and counts mismatches.
module emu_ram_tester #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    ID_WIDTH   = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    NUM_BURSTS = 16,
   parameter int                    BURST_LEN  = 16,
   parameter logic [31:0]           SEED       = 32'h1234_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [15:0]             err_count,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic [3:0]              m_axi_awqos,
   output logic [3:0]              m_axi_awregion,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   input  logic [ID_WIDTH-1:0]     m_axi_bid,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic                    m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic [3:0]              m_axi_arqos,
   output logic [3:0]              m_axi_arregion,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic [ID_WIDTH-1:0]     m_axi_rid,
   input  logic                    m_axi_rlast
);

   localparam int                    LANES       = DATA_WIDTH / 32;
   localparam logic [2:0]            AX_SIZE     = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [7:0]            AX_LEN      = 8'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
   localparam logic [31:0]           BEAT_STEP   = 32'(LANES);
   localparam logic [31:0]           BURST_STEP  = 32'(BURST_LEN * LANES);
   localparam logic [15:0]           LAST_BURST  = 16'(NUM_BURSTS - 1);
   localparam logic [15:0]           LAST_BEAT   = 16'(BURST_LEN - 1);

   typedef enum logic [2:0] {IDLE, W_AW, W_DATA, W_RESP, R_AR, R_DATA, DONE} state_t;

   state_t                  state;
   logic [15:0]             b, k;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             burst_pat, beat_pat;
   logic                    err_b, err_r, err_hit;

   // Lane j of a beat whose lane-0 word is base.
   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] base);
      logic [DATA_WIDTH-1:0] p;
      p = '0;
      for (int j = 0; j < LANES; j++) p[32*j +: 32] = base + 32'(j);
      return p;
   endfunction

   assign m_axi_awaddr   = addr_q;
   assign m_axi_araddr   = addr_q;
   assign m_axi_awlen    = AX_LEN;
   assign m_axi_arlen    = AX_LEN;
   assign m_axi_awsize   = AX_SIZE;
   assign m_axi_arsize   = AX_SIZE;
   assign m_axi_awburst  = 2'b01;
   assign m_axi_arburst  = 2'b01;
   assign m_axi_awid     = '0;
   assign m_axi_arid     = '0;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_awcache  = 4'd0;
   assign m_axi_arcache  = 4'd0;
   assign m_axi_awprot   = 3'd0;
   assign m_axi_arprot   = 3'd0;
   assign m_axi_awqos    = 4'd0;
   assign m_axi_arqos    = 4'd0;
   assign m_axi_awregion = 4'd0;
   assign m_axi_arregion = 4'd0;
   assign m_axi_wstrb    = '1;

   assign err_b = (state == W_RESP) && m_axi_bvalid && m_axi_bready &&
                  ((m_axi_bresp != 2'd0) || (m_axi_bid != '0));
   // A beat contributes at most one error regardless of how many fields are wrong.
   assign err_r = (state == R_DATA) && m_axi_rvalid && m_axi_rready &&
                  ((m_axi_rdata != pattern(beat_pat)) || (m_axi_rresp != 2'd0) ||
                   (m_axi_rid != '0) || (m_axi_rlast && (k != LAST_BEAT)));
   assign err_hit = err_b || err_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         b             <= '0;
         k             <= '0;
         addr_q        <= BASE_ADDR;
         burst_pat     <= SEED;
         beat_pat      <= SEED;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_count     <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wlast   <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         if (err_hit) begin
            error <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         end
         case (state)
            IDLE, DONE: if (start) begin
               state         <= W_AW;
               busy          <= 1'b1;
               done          <= 1'b0;
               error         <= 1'b0;
               err_count     <= '0;
               b             <= '0;
               addr_q        <= BASE_ADDR;
               burst_pat     <= SEED;
               m_axi_awvalid <= 1'b1;
            end
            W_AW: if (m_axi_awready) begin
               m_axi_awvalid <= 1'b0;
               m_axi_wvalid  <= 1'b1;
               m_axi_wdata   <= pattern(burst_pat);
               m_axi_wlast   <= (LAST_BEAT == 16'd0);
               beat_pat      <= burst_pat;
               k             <= '0;
               state         <= W_DATA;
            end
            W_DATA: if (m_axi_wready) begin
               k           <= k + 16'd1;
               beat_pat    <= beat_pat + BEAT_STEP;
               m_axi_wdata <= pattern(beat_pat + BEAT_STEP);
               m_axi_wlast <= (k + 16'd1 == LAST_BEAT);
               if (m_axi_wlast) begin
                  m_axi_wvalid <= 1'b0;
                  m_axi_bready <= 1'b1;
                  state        <= W_RESP;
               end
            end
            W_RESP: if (m_axi_bvalid) begin
               m_axi_bready <= 1'b0;
               if (b == LAST_BURST) begin
                  b             <= '0;
                  addr_q        <= BASE_ADDR;
                  burst_pat     <= SEED;
                  m_axi_arvalid <= 1'b1;
                  state         <= R_AR;
               end else begin
                  b             <= b + 16'd1;
                  addr_q        <= addr_q + BURST_BYTES;
                  burst_pat     <= burst_pat + BURST_STEP;
                  m_axi_awvalid <= 1'b1;
                  state         <= W_AW;
               end
            end
            R_AR: if (m_axi_arready) begin
               m_axi_arvalid <= 1'b0;
               m_axi_rready  <= 1'b1;
               beat_pat      <= burst_pat;
               k             <= '0;
               state         <= R_DATA;
            end
            // Only rlast closes a burst; the next burst restarts the pattern from its nominal base.
            R_DATA: if (m_axi_rvalid) begin
               k        <= k + 16'd1;
               beat_pat <= beat_pat + BEAT_STEP;
               if (m_axi_rlast) begin
                  m_axi_rready <= 1'b0;
                  if (b == LAST_BURST) begin
                     b     <= '0;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     b             <= b + 16'd1;
                     addr_q        <= addr_q + BURST_BYTES;
                     burst_pat     <= burst_pat + BURST_STEP;
                     m_axi_arvalid <= 1'b1;
                     state         <= R_AR;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_emu_ram_tester.sv
// Bench for emu_ram_tester: behavioural AXI slave with stalls/faults, queue scoreboard,
// plus a second instance with a wrapping base address.
module tb_emu_ram_tester;
   localparam logic [31:0] SEED = 32'h1234_0000;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance (default parameters)
   logic        start = 1'b0, busy, done, error;
   logic [15:0] err_count;
   logic        awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, arlock, rvalid, rready, rlast;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize, awprot, arprot;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  awid, arid, bid, rid, awcache, arcache, awqos, arqos, awregion, arregion;
   logic [63:0] wdata, rdata;

   emu_ram_tester dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
      .err_count(err_count),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
      .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awid(awid),
      .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
      .m_axi_awqos(awqos), .m_axi_awregion(awregion),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wlast(wlast),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp), .m_axi_bid(bid),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
      .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arid(arid),
      .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
      .m_axi_arqos(arqos), .m_axi_arregion(arregion),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rid(rid), .m_axi_rlast(rlast)
   );

   // Wrap instance: always-ready slave, read data all zero with rlast on every beat
   logic        x_start = 1'b0, x_busy, x_done, x_error;
   logic [15:0] x_err_count;
   logic        x_awvalid, x_awlock, x_wvalid, x_wlast, x_bready, x_arvalid, x_arlock, x_rready;
   logic        x_one = 1'b1;
   logic [31:0] x_awaddr, x_araddr;
   logic [7:0]  x_awlen, x_arlen, x_wstrb;
   logic [2:0]  x_awsize, x_arsize, x_awprot, x_arprot;
   logic [1:0]  x_awburst, x_arburst, x_resp = 2'd0;
   logic [3:0]  x_awid, x_arid, x_id = 4'd0, x_awcache, x_arcache, x_awqos, x_arqos;
   logic [3:0]  x_awregion, x_arregion;
   logic [63:0] x_wdata, x_rdata = 64'd0;

   emu_ram_tester #(.BASE_ADDR(32'hFFFF_FF80), .NUM_BURSTS(3), .BURST_LEN(8)) dut_wrap (
      .clk(clk), .rst(rst), .start(x_start), .busy(x_busy), .done(x_done), .error(x_error),
      .err_count(x_err_count),
      .m_axi_awvalid(x_awvalid), .m_axi_awready(x_one), .m_axi_awaddr(x_awaddr),
      .m_axi_awlen(x_awlen), .m_axi_awsize(x_awsize), .m_axi_awburst(x_awburst),
      .m_axi_awid(x_awid), .m_axi_awlock(x_awlock), .m_axi_awcache(x_awcache),
      .m_axi_awprot(x_awprot), .m_axi_awqos(x_awqos), .m_axi_awregion(x_awregion),
      .m_axi_wvalid(x_wvalid), .m_axi_wready(x_one), .m_axi_wdata(x_wdata),
      .m_axi_wstrb(x_wstrb), .m_axi_wlast(x_wlast),
      .m_axi_bvalid(x_one), .m_axi_bready(x_bready), .m_axi_bresp(x_resp), .m_axi_bid(x_id),
      .m_axi_arvalid(x_arvalid), .m_axi_arready(x_one), .m_axi_araddr(x_araddr),
      .m_axi_arlen(x_arlen), .m_axi_arsize(x_arsize), .m_axi_arburst(x_arburst),
      .m_axi_arid(x_arid), .m_axi_arlock(x_arlock), .m_axi_arcache(x_arcache),
      .m_axi_arprot(x_arprot), .m_axi_arqos(x_arqos), .m_axi_arregion(x_arregion),
      .m_axi_rvalid(x_one), .m_axi_rready(x_rready), .m_axi_rdata(x_rdata),
      .m_axi_rresp(x_resp), .m_axi_rid(x_id), .m_axi_rlast(x_one)
   );

   int checks = 0, errors = 0;
   logic [31:0] exp_aw[$], exp_ar[$], exp_aw2[$], exp_ar2[$];
   logic [64:0] exp_w[$];
   logic [16:0] exp_res[$];

   // Slave knobs, set by the stimulus between passes
   bit bp = 0, corrupt = 0, early = 0;
   int r_delay = 0, rburst = 0;
   logic [63:0] mem [int unsigned];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   // Behavioural slave: handshakes sampled at posedge, responses driven at negedge
   initial begin
      int unsigned wr_base, rd_base;
      int wk, rk, r_wait;
      bit b_pend, r_active, r_hs;
      logic [63:0] d;
      wr_base = 0; rd_base = 0; wk = 0; rk = 0; r_wait = 0; b_pend = 0; r_active = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0; arready = 0;
      rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
      forever begin
         @(posedge clk);
         r_hs = rvalid && rready;
         if (rst) begin
            b_pend = 0; r_active = 0; r_hs = 0; wk = 0; rk = 0;
         end else begin
            if (bvalid && bready) b_pend = 0;
            if (awvalid && awready) begin wr_base = awaddr >> 3; wk = 0; end
            if (wvalid && wready) begin
               mem[wr_base + wk] = wdata; wk++;
               if (wlast) b_pend = 1;
            end
            if (arvalid && arready) begin rd_base = araddr >> 3; rk = 0; r_active = 1; r_wait = r_delay; end
            if (r_hs) begin
               rk++;
               if (rlast) begin r_active = 0; rburst++; end
            end
         end
         @(negedge clk);
         awready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
         wready  = bp ? 1'($urandom_range(1, 0)) : 1'b1;
         arready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
         bvalid  = b_pend && (bvalid || !bp || 1'($urandom_range(1, 0)));
         if (!r_active) rvalid = 0;
         else if (rvalid && !r_hs) rvalid = 1;
         else if (r_wait > 0) begin r_wait--; rvalid = 0; end
         else begin
            d = mem.exists(rd_base + rk) ? mem[rd_base + rk] : 64'd0;
            if (corrupt && rburst == 3 && rk == 5) d[0] = ~d[0];
            rdata  = d;
            rlast  = (early && rburst == 0) ? (rk == 14) : (rk == 15);
            rvalid = bp ? 1'($urandom_range(1, 0)) : 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on every handshake and checks stall stability
   initial begin
      bit aw_st, w_st, ar_st, done_q, busy_q;
      logic [31:0] aw_p, ar_p;
      logic [64:0] w_p;
      aw_st = 0; w_st = 0; ar_st = 0; done_q = 0; busy_q = 0; aw_p = 0; ar_p = 0; w_p = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            aw_st = 0; w_st = 0; ar_st = 0; done_q = 0; busy_q = 0;
         end else begin
            if (aw_st) chk("aw_stable", {awvalid, awaddr}, {1'b1, aw_p});
            if (w_st)  chk("w_stable", {wvalid, wlast, wdata}, {1'b1, w_p});
            if (ar_st) chk("ar_stable", {arvalid, araddr}, {1'b1, ar_p});
            if (awvalid && awready) begin
               if (exp_aw.size() == 0) chk("aw_unexpected", awaddr, 'x);
               else chk("awaddr", awaddr, exp_aw.pop_front());
            end
            if (wvalid && wready) begin
               if (exp_w.size() == 0) chk("w_unexpected", wdata, 'x);
               else chk("wdata", {wlast, wdata}, exp_w.pop_front());
            end
            if (arvalid && arready) begin
               if (exp_ar.size() == 0) chk("ar_unexpected", araddr, 'x);
               else chk("araddr", araddr, exp_ar.pop_front());
            end
            if (x_awvalid) begin
               if (exp_aw2.size() == 0) chk("wrap_aw_unexpected", x_awaddr, 'x);
               else chk("wrap_awaddr", x_awaddr, exp_aw2.pop_front());
            end
            if (x_arvalid) begin
               if (exp_ar2.size() == 0) chk("wrap_ar_unexpected", x_araddr, 'x);
               else chk("wrap_araddr", x_araddr, exp_ar2.pop_front());
            end
            if (done && !done_q) begin
               if (exp_res.size() == 0) chk("done_unexpected", done, 1'b0);
               else chk("result", {error, err_count}, exp_res.pop_front());
               chk("busy_at_done", {busy_q, busy}, 2'b10);
            end
            aw_st = awvalid && !awready; aw_p = awaddr;
            w_st  = wvalid && !wready;   w_p  = {wlast, wdata};
            ar_st = arvalid && !arready; ar_p = araddr;
            done_q = done; busy_q = busy;
         end
      end
   end

   task automatic load_exp(input logic [16:0] res);
      logic [31:0] lo;
      for (int b = 0; b < 16; b++) begin
         exp_aw.push_back(32'(b * 128));
         exp_ar.push_back(32'(b * 128));
      end
      exp_w.push_back({1'b0, 64'h1234_0001_1234_0000});
      for (int g = 1; g < 256; g++) begin
         lo = SEED + 32'(2 * g);
         exp_w.push_back({g % 16 == 15, lo + 32'd1, lo});
      end
      exp_res.push_back(res);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic run_pass(input bit bp_i, input int rd_i, input bit cor_i, input bit erl_i,
                           input logic [16:0] res, input bit poke);
      int cyc;
      bp = bp_i; r_delay = rd_i; corrupt = cor_i; early = erl_i; rburst = 0;
      load_exp(res);
      pulse_start();
      chk("start_outputs", {awvalid, busy, done, error, err_count}, {4'b1100, 16'd0});
      cyc = 0;
      while (!done && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (poke && cyc == 200) begin start = 1'b1; @(negedge clk) start = 1'b0; end
      end
      chk("done_timeout", done, 1'b1);
      repeat (3) @(negedge clk);
      chk("queues_empty", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_res.size(), 0);
      chk("done_held", {done, busy}, 2'b10);
      exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      chk("reset_state", {busy, done, error, err_count, awvalid, wvalid, bready, arvalid, rready}, '0);
      chk("ax_consts", {awlen, awsize, awburst, arlen, arsize, arburst, wstrb},
          {8'd15, 3'd3, 2'b01, 8'd15, 3'd3, 2'b01, 8'hFF});
      @(negedge clk) rst = 1'b0;

      run_pass(0, 0, 0, 0, 17'h0_0000, 0);   // clean, zero latency
      run_pass(1, 25, 0, 0, 17'h0_0000, 0);  // read latency + backpressure everywhere
      run_pass(0, 0, 1, 0, 17'h1_0001, 0);   // corrupted beat 5 of burst 3
      run_pass(1, 3, 0, 1, 17'h1_0001, 0);   // early rlast on burst 0

      // Address wrap past 2^32 on the second instance
      exp_aw2 = '{32'hFFFF_FF80, 32'hFFFF_FFC0, 32'h0000_0000};
      exp_ar2 = '{32'hFFFF_FF80, 32'hFFFF_FFC0, 32'h0000_0000};
      @(negedge clk) x_start = 1'b1;
      @(negedge clk) x_start = 1'b0;
      cyc = 0;
      while (!x_done && cyc < 2000) begin @(negedge clk); cyc++; end
      chk("wrap_done_timeout", x_done, 1'b1);
      chk("wrap_queues_empty", exp_aw2.size() + exp_ar2.size(), 0);
      chk("wrap_result", {x_error, x_err_count}, 17'h1_0003);

      // Reset in the middle of a write burst, then a clean pass with a start pulse while busy
      bp = 0; r_delay = 0; corrupt = 0; early = 0; rburst = 0;
      load_exp(17'h0_0000);
      pulse_start();
      cyc = 0;
      while (!wvalid && cyc < 100) begin @(negedge clk); cyc++; end
      chk("reach_wdata", wvalid, 1'b1);
      @(negedge clk) rst = 1'b1;
      #1;
      chk("reset_midpass", {awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_count},
          '0);
      exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
      @(negedge clk) rst = 1'b0;
      run_pass(0, 0, 0, 0, 17'h0_0000, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/emu_ram_tester.md
Name: emu_ram_tester

Overview:
- Self-checking AXI4 traffic generator that sits directly upstream of the emulated RAM model and drives its slave port.
- On a start pulse it writes NUM_BURSTS INCR bursts of a deterministic pattern from BASE_ADDR, then reads every burst back and compares it against the pattern.
- It reports done, a sticky error flag and an error count.
- Used as a bring-up and regression source for the RAM model and its timing wrappers.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width; multiple of 32, max 1024.
- ID_WIDTH, 4, AXI ID width.
- BASE_ADDR, 0, first byte address; must be aligned to a DATA_WIDTH/8 boundary.
- NUM_BURSTS, 16, number of bursts, 1..65535.
- BURST_LEN, 16, beats per burst, 1..256.
- SEED, 32'h1234_0000, pattern seed.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous active-high
- start  in  1  begin a test pass; single-cycle pulse
- busy  out  1  high from the cycle after an accepted start until done rises
- done  out  1  pass complete; held until the next accepted start
- error  out  1  sticky; set by any mismatch in the current pass
- err_count  out  16  saturating count of errors in the current pass
- m_axi_awvalid/awready  out/in  1  write address handshake
- m_axi_awaddr  out  ADDR_WIDTH  burst address
- m_axi_awlen/awsize/awburst  out  8/3/2  BURST_LEN-1, log2(DATA_WIDTH/8), 2'b01
- m_axi_awid/awlock/awcache/awprot/awqos/awregion  out  ID_WIDTH/1/4/3/4/4  constant 0
- m_axi_wvalid/wready  out/in  1  write data handshake
- m_axi_wdata/wstrb/wlast  out  DATA_WIDTH/DATA_WIDTH/8/1  pattern data, all-ones strobe, last beat
- m_axi_bvalid/bready  in/out  1  write response handshake
- m_axi_bresp/bid  in  2/ID_WIDTH  write response status and ID
- m_axi_arvalid/arready  out/in  1  read address handshake
- m_axi_araddr/arlen/arsize/arburst  out  same encoding as the AW channel
- m_axi_arid/arlock/arcache/arprot/arqos/arregion  out  constant 0
- m_axi_rvalid/rready  in/out  1  read data handshake
- m_axi_rdata/rresp/rid/rlast  in  DATA_WIDTH/2/ID_WIDTH/1  read data, status, ID, last beat

Behaviour:
- Reset values: all valid/ready outputs 0; busy, done and error 0; err_count 0; state IDLE; burst and beat counters 0.
- Reset mid-pass: the block drops to IDLE immediately and abandons any open AXI transaction; the RAM model shares the same reset.
- FSM states: IDLE, W_AW, W_DATA, W_RESP, R_AR, R_DATA, DONE.
- Start:
  - Accepted in IDLE or DONE: clears done, error and err_count; zeroes the burst counter b; enters W_AW.
  - Ignored in all other states.
- Outputs are registered. awvalid rises the cycle after start.
- Every valid is held with stable payload until its ready is sampled high.
- W_AW:
  - awvalid=1, awaddr = BASE_ADDR + b*BURST_LEN*DATA_WIDTH/8, taken modulo 2^ADDR_WIDTH.
  - On handshake, go to W_DATA with beat counter k=0.
- W_DATA:
  - wvalid=1; k increments on each handshake.
  - wlast=1 exactly when k==BURST_LEN-1; after the last handshake go to W_RESP.
  - W data never precedes its AW handshake.
- Pattern: 32-bit lane j of global beat g = b*BURST_LEN+k is SEED + g*(DATA_WIDTH/32) + j, modulo 2^32.
- W_RESP:
  - bready=1.
  - On handshake, one error if bresp!=0 or bid!=0.
  - Then b++; if b==NUM_BURSTS, zero b and go to R_AR; else go to W_AW.
- R_AR: arvalid=1 with the same address rule as W_AW; on handshake go to R_DATA with k=0.
- R_DATA: rready=1. On each handshake:
  - Each beat adds at most one error, counted if rdata differs from the pattern, rresp!=0, rid!=0, or rlast with k!=BURST_LEN-1.
  - The burst ends only on an rlast handshake.
  - Beats with k > BURST_LEN-1 are compared against the pattern at k.
  - On burst end: b++; if b==NUM_BURSTS go to DONE, else go to R_AR.
- Error accounting: error goes high on the cycle after the first error. err_count saturates at 16'hFFFF.
- DONE: done=1, busy=0; stay until the next start.
- Exactly one burst is outstanding at any time. Reads begin only after every write response has been received.

Test Plan:
- Defaults, zero-latency slave, start pulse → 16 AW and 16 AR handshakes, 256 W beats; done=1, error=0, err_count=0; first wdata = 64'h1234_0001_1234_0000.
- Slave with R_DELAY=25 and random ready backpressure on every channel → valid/payload stable under stall, same clean result, busy low exactly when done rises.
- Slave that corrupts bit 0 of beat 5 of burst 3 → error=1, err_count=1.
- Slave that asserts rlast on beat 14 of burst 0, BURST_LEN=16 → err_count=1; next AR issued with araddr=BASE_ADDR+128.
- BASE_ADDR=32'hFFFF_FF80, NUM_BURSTS=2, BURST_LEN=8 → second awaddr=32'hFFFF_FFC0; third request wraps to 0 when NUM_BURSTS=3.
- rst asserted during W_DATA, then start → all valids low within the reset, fresh pass completes cleanly; start pulsed while busy is ignored.
